// File: rtl/prog_counter.sv
// ============================================================================
// Module   : prog_counter
// Purpose  : Programmable up/down counter with runtime limit, wrap/saturate
//            mode, load, terminal-count pulse and sticky overflow flag.
//            Optional clock-enable prescaler under macro COUNTER_PRESCALE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module prog_counter #(
  parameter int WIDTH    = 12,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_zero = '0;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("prog_counter: WIDTH must be in 2..32");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("prog_counter: PRESCALE must be in 1..65535");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             w_step_qual;

`ifdef COUNTER_PRESCALE_EN
  localparam logic [15:0] c_presc_last = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;

  assign w_step_qual = (presc_q == c_presc_last);

  // Load restarts the divide sequence so the first step after a load is a full period away.
  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = w_step_qual ? 16'd0 : presc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign w_step_qual = 1'b1;
`endif

  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_dec          = count_q - c_one;
  assign w_load_clamped = (load_val > limit) ? limit : load_val;

  // Boundaries are detected before the add/subtract, so no carry/borrow bit is needed.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = w_load_clamped;
      ovf_d   = 1'b0;
    end else if (en && w_step_qual) begin
      if (up) begin
        if (count_q >= limit) begin
          count_d = sat ? limit : c_zero;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + c_one;
        end
      end else begin
        if (count_q == c_zero) begin
          count_d = sat ? c_zero : limit;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = (w_dec > limit) ? limit : w_dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_counter.sv
// ============================================================================
// Module   : tb_prog_counter
// Purpose  : Scoreboard bench for prog_counter with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prog_counter;

  localparam int WIDTH    = 12;
  localparam int PRESCALE = 4;
`ifdef COUNTER_PRESCALE_EN
  localparam int PM = PRESCALE;
`else
  localparam int PM = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en = 1'b0;
  logic             up = 1'b1;
  logic             sat = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] limit = '0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  always #5 clk = ~clk;

  prog_counter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat),
    .limit(limit), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .ovf(ovf)
  );

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  int m_count = 0;
  int m_pre   = 0;
  bit m_tc    = 0;
  bit m_ovf   = 0;

  // Reference: integer arithmetic over the range [0, lim], steps counted in enabled cycles.
  task automatic drive(input bit r, input bit ld, input int lv, input bit e,
                       input bit u, input bit s, input int lim);
    exp_t x;
    bit   step;
    @(negedge clk);
    reset = r; load = ld; load_val = WIDTH'(lv); en = e; up = u; sat = s;
    limit = WIDTH'(lim);
    step = 0;
    if (r) begin
      m_count = 0; m_tc = 0; m_ovf = 0; m_pre = 0;
    end else if (ld) begin
      m_count = (lv < lim) ? lv : lim;
      m_tc = 0; m_ovf = 0; m_pre = 0;
    end else begin
      m_tc = 0;
      if (e) begin
        m_pre = m_pre + 1;
        if (m_pre == PM) begin
          step  = 1;
          m_pre = 0;
        end
      end
      if (step) begin
        if (u) begin
          if (m_count < lim) m_count = m_count + 1;
          else begin
            m_count = s ? lim : 0;
            m_tc = 1; m_ovf = 1;
          end
        end else begin
          if (m_count > 0) m_count = (m_count - 1 < lim) ? m_count - 1 : lim;
          else begin
            m_count = s ? 0 : lim;
            m_tc = 1; m_ovf = 1;
          end
        end
      end
    end
    x.cnt = m_count; x.tc = m_tc; x.ovf = m_ovf;
    sbq.push_back(x);
  endtask

  task automatic steps(input int n, input bit u, input bit s, input int lim);
    repeat (n * PM) drive(0, 0, 0, 1, u, s, lim);
  endtask

  task automatic chk(input string nm, input int ec, input bit etc, input bit eovf);
    @(posedge clk);
    #2;
    total++;
    if (count !== WIDTH'(ec) || tc !== etc || ovf !== eovf) begin
      bad++;
      $display("FAIL %s got count=%0d tc=%0b ovf=%0b want count=%0d tc=%0b ovf=%0b",
               nm, count, tc, ovf, ec, etc, eovf);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      total++;
      if (count !== WIDTH'(mon_e.cnt) || tc !== mon_e.tc || ovf !== mon_e.ovf) begin
        bad++;
        $display("FAIL scoreboard t=%0t got count=%0d tc=%0b ovf=%0b want count=%0d tc=%0b ovf=%0b",
                 $time, count, tc, ovf, mon_e.cnt, mon_e.tc, mon_e.ovf);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_lim;
    drive(1, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("reset_state", 0, 0, 0);

    // full-range wrap up
    steps(4095, 1, 0, 4095);
    chk("reach_max", 4095, 0, 0);
    steps(1, 1, 0, 4095);
    chk("wrap_up", 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0, 4095);
    chk("tc_one_cycle", 0, 0, 1);

    // down wrap
    drive(0, 1, 0, 0, 0, 0, 9);
    chk("load_zero", 0, 0, 0);
    steps(1, 0, 0, 9);
    chk("down_wrap", 9, 1, 1);
    steps(1, 0, 0, 9);
    chk("down_8", 8, 0, 1);
    steps(1, 0, 0, 9);
    chk("down_7", 7, 0, 1);

    // saturate at limit
    drive(0, 1, 3, 0, 1, 1, 5);
    steps(1, 1, 1, 5);
    chk("sat_4", 4, 0, 0);
    steps(1, 1, 1, 5);
    chk("sat_5", 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      steps(1, 1, 1, 5);
      chk("sat_rail", 5, 1, 1);
    end

    // load clamp beats step
    drive(0, 1, 200, 1, 1, 0, 100);
    chk("load_clamp", 100, 0, 0);
    steps(1, 1, 0, 50);
    chk("limit_drop_wrap", 0, 1, 1);

    // reset beats load
    drive(0, 1, 7, 0, 1, 0, 100);
    drive(1, 1, 3, 1, 1, 0, 100);
    chk("reset_mid_op", 0, 0, 0);

    // degenerate range
    drive(0, 1, 5, 0, 1, 0, 0);
    steps(1, 1, 0, 0);
    chk("limit0_up", 0, 1, 1);
    steps(1, 0, 1, 0);
    chk("limit0_down_sat", 0, 1, 1);

    // prescaler cadence and en freeze (scoreboard-checked)
    drive(0, 1, 0, 0, 1, 0, 100);
    repeat (12) drive(0, 0, 0, 1, 1, 0, 100);
    repeat (2) drive(0, 0, 0, 0, 1, 0, 100);
    repeat (8) drive(0, 0, 0, 1, 1, 0, 100);

    // randomized traffic
    cur_lim = 10;
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, e, u, s;
      int lv;
      if ($urandom_range(0, 31) == 0)
        cur_lim = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4095));
      r  = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 1) == 1);
      s  = ($urandom_range(0, 1) == 1);
      lv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4095));
      drive(r, ld, lv, e, u, s, cur_lim);
    end

    drive(0, 0, 0, 0, 1, 0, cur_lim);
    @(posedge clk);
    #3;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_counter.md
# prog_counter

Parametrised, programmable up/down counter that generalises the fixed 12-bit wrap-to-zero counter. It adds a runtime limit, direction control, enable, synchronous load, wrap-or-saturate mode, a terminal-count pulse and a sticky overflow flag. It sits in the timing/sequencing datapath and drives address generators, display multiplexers and event timers.

## Interface
- `WIDTH`, default 12: counter width in bits; legal range 2 to 32.
- `PRESCALE`, default 1: clock-enable divide ratio; legal range 1 to 65535. Used only when `COUNTER_PRESCALE_EN` is defined.
- `clk`  in  1: rising-edge clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `en`  in  1: count enable; a step is allowed only when high.
- `up`  in  1: direction; 1 = increment, 0 = decrement.
- `sat`  in  1: boundary mode; 1 = saturate, 0 = wrap.
- `limit`  in  WIDTH: upper bound of the count range, sampled every cycle.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  WIDTH: value to load.
- `count`  out  WIDTH: registered count.
- `tc`  out  1: registered terminal-count pulse.
- `ovf`  out  1: sticky flag; set on any wrap or saturation event.

## Operation
- Reset (synchronous, active-high) forces `count`=0, `tc`=0, `ovf`=0 and clears the prescaler. Reset has highest priority.
- Priority per cycle: reset, then load, then step, then hold.
- Load: `count` <= min(`load_val`, `limit`). Load sets `tc`=0, clears `ovf` and restarts the prescaler. Load takes effect regardless of `en`.
- Step: occurs when `en`=1 and the step qualifier is 1. The qualifier is always 1 when the prescaler is compiled out.
- Up step, interior case (`count` < `limit`): `count`+1.
- Up step, boundary case (`count` >= `limit`):
  - wrap mode: `count` <= 0.
  - saturate mode: `count` <= `limit`.
- Down step, interior case (`count` > 0): `count`-1. If `count` > `limit`, the result is clamped to `limit`.
- Down step, boundary case (`count`=0):
  - wrap mode: `count` <= `limit`.
  - saturate mode: `count` holds at 0.
- Boundary event: any step taken in a boundary case, in either mode. Each boundary event sets `tc`=1 for that edge and sets `ovf`=1.
  - In saturate mode, every attempted step at the boundary is an event, so `tc` stays high while `en` holds the counter at the rail.
- A change to `limit` while `count` > `limit` is legal: the next up step is a boundary event.
- `limit`=0: the range is {0}. Every step is a boundary event and `count` stays 0.
- Arithmetic is unsigned WIDTH-bit. No intermediate result exceeds WIDTH bits, because the boundary is detected before the increment or decrement.

## Timing
- All outputs are registered. Output changes one edge after the qualifying inputs are sampled; latency is 1 cycle.
- `tc` is high for the cycle immediately after a boundary-event edge, coincident with the wrapped or saturated `count`. Otherwise it is 0.
- `ovf` rises on the same edge as `tc`. It remains high until reset or load.
- Toggling `up`, `sat` or `limit` takes effect on the next edge; there is no pipeline to flush.
- Reset in mid-operation wins over a simultaneous load or step on the same edge.

## Configuration
- Macro: `COUNTER_PRESCALE_EN`.
- Defined:
  - An internal 16-bit prescaler advances on each cycle with `en`=1.
  - The step qualifier is 1 only on the cycle where the prescaler equals `PRESCALE`-1; the prescaler then returns to 0.
  - `en`=0 freezes the prescaler.
  - Reset and load clear the prescaler.
  - `PRESCALE`=1 behaves identically to the undefined case.
- Undefined: no prescaler logic is generated, `PRESCALE` is ignored, and every `en` cycle is a step.

## Test plan
- Reset then wrap-up: `WIDTH`=12, `limit`=4095, `up`=1, `sat`=0, `en`=1 for 4096 cycles. Required: `count` reaches 4095, then returns to 0 with `tc`=1 for exactly one cycle and `ovf`=1.
- Down wrap: load 0 with `limit`=9 and `up`=0. Required: next step gives `count`=9 with `tc`=1; the following steps give 8, 7, … with `tc`=0.
- Saturate: `limit`=5, `sat`=1, `up`=1, start from 3, 5 enabled cycles. Required: `count` goes 4, 5, 5, 5, 5, and `tc` is high on each of the last 3 cycles.
- Load clamp and priority: `load_val`=200 and `limit`=100, with `load`=1 and `en`=1 on the same cycle. Required: `count`=100, `ovf` cleared, no step applied. Next: `limit` changed to 50 and an up step gives `count`=0, `tc`=1.
- Reset mid-operation: `reset`=1 while `load`=1 and `count`=7. Required: `count`=0, `tc`=0, `ovf`=0 on the next edge.
- Prescaler (`COUNTER_PRESCALE_EN` defined, `PRESCALE`=4): `en` held high for 12 cycles. Required: `count` increments only on cycles 4, 8 and 12. Dropping `en` for 2 cycles delays the next increment by 2 cycles.
